// File: rtl/an_decoder_seq_if.sv
// Handshake and result bundle between the AN-coded datapath and the sequential decoder.
// The decoder takes the slave modport; the producer/consumer side takes master.
interface an_decoder_seq_if #(
  parameter int CW = 18,
  parameter int NW = 12,
  parameter int SW = 16,
  parameter int PW = $clog2(CW)
);
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] ane;
  logic          out_valid;
  logic          out_ready;
  logic [NW-1:0] n_out;
  logic [PW-1:0] err_pos;
  logic          err_neg;
  logic          corrected;
  logic          uncorrectable;
  logic [SW-1:0] cnt_corr;
  logic [SW-1:0] cnt_unc;

  modport master (
    output in_valid, ane, out_ready,
    input  in_ready, out_valid, n_out, err_pos, err_neg, corrected, uncorrectable,
           cnt_corr, cnt_unc
  );

  modport slave (
    input  in_valid, ane, out_ready,
    output in_ready, out_valid, n_out, err_pos, err_neg, corrected, uncorrectable,
           cnt_corr, cnt_unc
  );
endinterface

// File: rtl/an_decoder_seq.sv
// Multi-cycle AN-code decoder: bit-serial residue, iterative single-error search,
// correction, then restoring division by A, with saturating event counters.
module an_decoder_seq #(
  parameter int A  = 37,
  parameter int NW = 12,
  parameter int CW = 18,
  parameter int RW = 6,
  parameter int SW = 16
) (
  input  logic               clk,
  input  logic               rst,
  an_decoder_seq_if.slave    bus
);
  localparam int PW = $clog2(CW);
  localparam logic [RW:0]   A_X  = (RW+1)'(A);
  localparam logic [PW-1:0] LAST = PW'(CW-1);

  typedef enum logic [2:0] {IDLE, RES, SRCH, DIV, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] code_q, code_d;
  logic [RW-1:0] r_q, r_d;
  logic [RW-1:0] p_q, p_d;
  logic          hit_q, hit_d;
  logic          neg_q, neg_d;
  logic [PW-1:0] pos_q, pos_d;
  logic          unc_q, unc_d;
  logic          out_valid_q, out_valid_d;
  logic [NW-1:0] n_out_q, n_out_d;
  logic [PW-1:0] err_pos_q, err_pos_d;
  logic          err_neg_q, err_neg_d;
  logic          corr_q, corr_d;
  logic          unc_out_q, unc_out_d;
  logic [SW-1:0] cnt_corr_q, cnt_corr_d;
  logic [SW-1:0] cnt_unc_q, cnt_unc_d;

  logic [RW:0]   shift_sum, shift_red, p_dbl, p_red;
  logic          shift_ge;
  logic [RW-1:0] p_neg;
  logic          hit_p, hit_n, hit_new, hit_now, neg_now;
  logic [PW-1:0] pos_now;
  logic [CW:0]   pow2, fix_sum;
  logic          last, bad;

  // Residue accumulation and division share the same shift-in-MSB / conditional-subtract step.
  always_comb begin
    shift_sum = {r_q, code_q[CW-1]};
    shift_ge  = (shift_sum >= A_X);
    shift_red = shift_ge ? (shift_sum - A_X) : shift_sum;
    p_dbl     = {p_q, 1'b0};
    p_red     = (p_dbl >= A_X) ? (p_dbl - A_X) : p_dbl;
    p_neg     = RW'(A) - p_q;
    hit_p     = (r_q == p_q);
    hit_n     = (r_q == p_neg);
    hit_new   = !hit_q && (r_q != '0) && (hit_p || hit_n);
    hit_now   = hit_q || hit_new;
    neg_now   = hit_q ? neg_q : !hit_p;
    pos_now   = hit_q ? pos_q : cnt_q;
    pow2      = (CW+1)'(1) << pos_now;
    fix_sum   = neg_now ? ({1'b0, code_q} + pow2) : ({1'b0, code_q} - pow2);
    last      = (cnt_q == LAST);
    bad       = unc_q || (r_q != '0) || (|code_q[CW-1:NW]);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    r_d         = r_q;
    p_d         = p_q;
    hit_d       = hit_q;
    neg_d       = neg_q;
    pos_d       = pos_q;
    unc_d       = unc_q;
    out_valid_d = out_valid_q;
    n_out_d     = n_out_q;
    err_pos_d   = err_pos_q;
    err_neg_d   = err_neg_q;
    corr_d      = corr_q;
    unc_out_d   = unc_out_q;
    cnt_corr_d  = cnt_corr_q;
    cnt_unc_d   = cnt_unc_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          code_d  = bus.ane;
          r_d     = '0;
          p_d     = RW'(1);
          cnt_d   = '0;
          hit_d   = 1'b0;
          neg_d   = 1'b0;
          pos_d   = '0;
          unc_d   = 1'b0;
          state_d = RES;
        end
      end

      // Rotating the codeword through CW steps returns it intact for the correction step.
      RES: begin
        r_d    = shift_red[RW-1:0];
        code_d = {code_q[CW-2:0], code_q[CW-1]};
        cnt_d  = cnt_q + PW'(1);
        if (last) begin
          cnt_d   = '0;
          state_d = SRCH;
        end
      end

      SRCH: begin
        if (hit_new) begin
          hit_d = 1'b1;
          neg_d = !hit_p;
          pos_d = cnt_q;
        end
        p_d   = p_red[RW-1:0];
        cnt_d = cnt_q + PW'(1);
        if (last) begin
          cnt_d   = '0;
          r_d     = '0;
          state_d = DIV;
          if (r_q != '0) begin
            if (!hit_now) begin
              unc_d = 1'b1;
            end else begin
              code_d = fix_sum[CW-1:0];
              unc_d  = fix_sum[CW];
            end
          end
        end
      end

      // code_q doubles as dividend (shifted out at the top) and quotient (shifted in at the bottom).
      DIV: begin
        r_d    = shift_red[RW-1:0];
        code_d = {code_q[CW-2:0], shift_ge};
        cnt_d  = cnt_q + PW'(1);
        if (last) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          if (bad) begin
            n_out_d   = '0;
            err_pos_d = '0;
            err_neg_d = 1'b0;
            corr_d    = 1'b0;
            unc_out_d = 1'b1;
          end else begin
            n_out_d   = code_q[NW-1:0];
            err_pos_d = pos_q;
            err_neg_d = neg_q;
            corr_d    = hit_q;
            unc_out_d = 1'b0;
          end
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
          if (corr_q && (cnt_corr_q != {SW{1'b1}})) cnt_corr_d = cnt_corr_q + SW'(1);
          if (unc_out_q && (cnt_unc_q != {SW{1'b1}})) cnt_unc_d = cnt_unc_q + SW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      code_q      <= '0;
      r_q         <= '0;
      p_q         <= '0;
      hit_q       <= 1'b0;
      neg_q       <= 1'b0;
      pos_q       <= '0;
      unc_q       <= 1'b0;
      out_valid_q <= 1'b0;
      n_out_q     <= '0;
      err_pos_q   <= '0;
      err_neg_q   <= 1'b0;
      corr_q      <= 1'b0;
      unc_out_q   <= 1'b0;
      cnt_corr_q  <= '0;
      cnt_unc_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      r_q         <= r_d;
      p_q         <= p_d;
      hit_q       <= hit_d;
      neg_q       <= neg_d;
      pos_q       <= pos_d;
      unc_q       <= unc_d;
      out_valid_q <= out_valid_d;
      n_out_q     <= n_out_d;
      err_pos_q   <= err_pos_d;
      err_neg_q   <= err_neg_d;
      corr_q      <= corr_d;
      unc_out_q   <= unc_out_d;
      cnt_corr_q  <= cnt_corr_d;
      cnt_unc_q   <= cnt_unc_d;
    end
  end

  assign bus.in_ready      = (state_q == IDLE);
  assign bus.out_valid     = out_valid_q;
  assign bus.n_out         = n_out_q;
  assign bus.err_pos       = err_pos_q;
  assign bus.err_neg       = err_neg_q;
  assign bus.corrected     = corr_q;
  assign bus.uncorrectable = unc_out_q;
  assign bus.cnt_corr      = cnt_corr_q;
  assign bus.cnt_unc       = cnt_unc_q;
endmodule

// File: tb/tb_an_decoder_seq.sv
// Directed plus randomized bench for an_decoder_seq; expected results come from an
// arithmetic model of AN decoding (modulo, search over powers of two, integer divide).
module tb_an_decoder_seq;
  localparam int A   = 37;
  localparam int NW  = 12;
  localparam int CW  = 18;
  localparam int RW  = 6;
  localparam int SW  = 16;
  localparam int LAT = 3*CW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vectors = 0;
  int   n_miscompares = 0;
  longint exp_corr = 0;
  longint exp_unc = 0;

  always #5 clk = ~clk;

  an_decoder_seq_if #(.CW(CW), .NW(NW), .SW(SW)) bus ();

  an_decoder_seq #(.A(A), .NW(NW), .CW(CW), .RW(RW), .SW(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vectors++;
    assert (obs === expv) else begin
      n_miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Decoding straight from the code definition: N*A with at most one +/-2^i error.
  function automatic void ref_decode(input longint code, output longint n, output longint pos,
                                     output longint neg, output longint corr, output longint unc);
    longint r, c, pw;
    bit found;
    r = code % A; c = code; found = 0;
    n = 0; pos = 0; neg = 0; corr = 0; unc = 0;
    if (r != 0) begin
      for (int i = 0; i < CW; i++) begin
        pw = longint'(1) << i;
        if (!found && (pw % A) == r) begin
          c = code - pw; pos = i; neg = 0; found = 1;
        end else if (!found && (A - (pw % A)) == r) begin
          c = code + pw; pos = i; neg = 1; found = 1;
        end
      end
      if (!found) unc = 1;
      else corr = 1;
      if (c < 0 || c >= (longint'(1) << CW)) unc = 1;
    end
    if (!unc && ((c % A) != 0 || (c / A) > ((longint'(1) << NW) - 1))) unc = 1;
    if (unc) begin
      n = 0; pos = 0; neg = 0; corr = 0;
    end else begin
      n = c / A;
    end
  endfunction

  task automatic applyStimulus(input logic [CW-1:0] code);
    int k = 0;
    while (!bus.in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    checkOutput("accept.in_ready", 64'(bus.in_ready), 64'd1);
    bus.ane = code;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.ane = CW'($urandom);
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic checkResult(input logic [CW-1:0] code, input string tag);
    longint n, pos, neg, corr, unc;
    ref_decode(longint'(code), n, pos, neg, corr, unc);
    checkOutput({tag, ".n_out"}, 64'(bus.n_out), 64'(n));
    checkOutput({tag, ".corrected"}, 64'(bus.corrected), 64'(corr));
    checkOutput({tag, ".uncorrectable"}, 64'(bus.uncorrectable), 64'(unc));
    checkOutput({tag, ".err_pos"}, 64'(bus.err_pos), 64'(pos));
    checkOutput({tag, ".err_neg"}, 64'(bus.err_neg), 64'(neg));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    if (corr != 0) exp_corr++;
    if (unc != 0) exp_unc++;
    checkOutput({tag, ".out_valid_drop"}, 64'(bus.out_valid), 64'd0);
    checkOutput({tag, ".in_ready_back"}, 64'(bus.in_ready), 64'd1);
    checkOutput({tag, ".cnt_corr"}, 64'(bus.cnt_corr), 64'(exp_corr));
    checkOutput({tag, ".cnt_unc"}, 64'(bus.cnt_unc), 64'(exp_unc));
  endtask

  task automatic runDecode(input logic [CW-1:0] code, input string tag);
    int lat;
    applyStimulus(code);
    waitResult(lat);
    checkOutput({tag, ".latency"}, 64'(lat), 64'(LAT));
    checkResult(code, tag);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    bit ok;
    longint pa, pb, n_bad;
    logic [CW-1:0] code, base;

    bus.in_valid = 1'b0;
    bus.ane = '0;
    bus.out_ready = 1'b0;

    n_bad = 0;
    for (int i = 0; i < CW; i++) begin
      pa = (longint'(1) << i) % A;
      if (pa == 0 || (A - pa) == pa) n_bad++;
      for (int j = 0; j < i; j++) begin
        pb = (longint'(1) << j) % A;
        if (pa == pb || pa == A - pb || (A - pa) == pb) n_bad++;
      end
    end
    checkOutput("param.residues_distinct", 64'(n_bad), 64'd0);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset.in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("reset.out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset.n_out", 64'(bus.n_out), 64'd0);
    checkOutput("reset.cnt_corr", 64'(bus.cnt_corr), 64'd0);
    checkOutput("reset.cnt_unc", 64'(bus.cnt_unc), 64'd0);

    runDecode(18'd20868, "clean");
    runDecode(18'd20869, "pos0");
    runDecode(18'd151940, "pos17");
    checkOutput("pos.cnt_corr_two", 64'(bus.cnt_corr), 64'd2);
    runDecode(18'd4484, "neg14");
    runDecode(18'd20864, "neg2");
    runDecode(18'd262143, "overflow");
    runDecode(18'd185000, "range");
    checkOutput("fail.cnt_unc_two", 64'(bus.cnt_unc), 64'd2);

    // Backpressure: hold the result, poke in_valid, nothing may move.
    applyStimulus(18'd151940);
    waitResult(lat);
    checkOutput("bp.latency", 64'(lat), 64'(LAT));
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        bus.ane = 18'd4484;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      checkOutput("bp.out_valid_hold", 64'(bus.out_valid), 64'd1);
      checkOutput("bp.in_ready_low", 64'(bus.in_ready), 64'd0);
      checkOutput("bp.n_out_hold", 64'(bus.n_out), 64'd564);
      checkOutput("bp.err_pos_hold", 64'(bus.err_pos), 64'd17);
    end
    bus.in_valid = 1'b0;
    checkResult(18'd151940, "bp");
    runDecode(18'd20869, "bp_next");

    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) begin
        code = CW'($urandom);
      end else begin
        base = CW'($urandom_range(0, (1 << NW) - 1) * A);
        lat = int'($urandom_range(0, CW - 1));
        code = ($urandom_range(0, 1) == 1) ? base + (CW'(1) << lat) : base - (CW'(1) << lat);
      end
      runDecode(code, "random");
    end

    // Reset mid-decode must abort with no result and reset-valued outputs.
    applyStimulus(18'd20869);
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_corr = 0;
    exp_unc = 0;
    checkOutput("rst.in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("rst.out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst.n_out", 64'(bus.n_out), 64'd0);
    checkOutput("rst.err_pos", 64'(bus.err_pos), 64'd0);
    checkOutput("rst.err_neg", 64'(bus.err_neg), 64'd0);
    checkOutput("rst.corrected", 64'(bus.corrected), 64'd0);
    checkOutput("rst.uncorrectable", 64'(bus.uncorrectable), 64'd0);
    checkOutput("rst.cnt_corr", 64'(bus.cnt_corr), 64'd0);
    checkOutput("rst.cnt_unc", 64'(bus.cnt_unc), 64'd0);
    ok = 1'b1;
    repeat (70) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) ok = 1'b0;
    end
    checkOutput("rst.no_out_valid", 64'(ok), 64'd1);

    for (int i = 0; i < CW; i++) begin
      code = 18'd20868 + (CW'(1) << i);
      runDecode(code, "sweep_pos");
    end
    for (int i = 0; i < CW; i++) begin
      if ((1 << i) <= 20868) begin
        code = 18'd20868 - (CW'(1) << i);
        runDecode(code, "sweep_neg");
      end
    end
    checkOutput("sweep.cnt_corr_33", 64'(bus.cnt_corr), 64'd33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end
endmodule
